// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with draw-window decode.
//   clk25       in   pixel clock, all state on the rising edge
//   reset       in   asynchronous active-high reset
//   enable      in   count advance; low freezes counters and the output pipeline
//   hSync/vSync out  sync levels; the asserted level is set by H_POL/V_POL
//   video       out  inside the H_ACTIVE x V_ACTIVE visible area
//   draw        out  inside the draw window, clipped to the visible area
//   xCoord      out  window-relative x >> SCALE_LOG2, 0 outside the window
//   yCoord      out  window-relative y >> SCALE_LOG2, 0 outside the window
//   lineStart   out  pulse at hCount 0
//   frameStart  out  pulse at hCount 0, vCount 0
// Outputs show the decode of the count state 1+PIPE enabled edges earlier.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned WIN_X0     = 0,
  parameter int unsigned WIN_Y0     = 0,
  parameter int unsigned WIN_W      = 256,
  parameter int unsigned WIN_H      = 320,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 9,
  parameter int unsigned PIPE       = 0
) (
  input  logic           clk25,
  input  logic           reset,
  input  logic           enable,
  output logic           hSync,
  output logic           vSync,
  output logic           video,
  output logic           draw,
  output logic [X_W-1:0] xCoord,
  output logic [Y_W-1:0] yCoord,
  output logic           lineStart,
  output logic           frameStart
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HC_W     = $clog2(H_TOTAL);
  localparam int unsigned VC_W     = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;

  // One pipeline stage worth of output state.
  typedef struct packed {
    logic           hs;
    logic           vs;
    logic           video;
    logic           draw;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           ls;
    logic           fs;
  } vid_out_t;

  localparam vid_out_t RST_OUT = '{hs: ~H_POL, vs: ~V_POL, default: '0};

  logic [HC_W-1:0] h_cnt_q, h_cnt_d;
  logic [VC_W-1:0] v_cnt_q, v_cnt_d;

  // Raster counters: h wraps every line, v advances on the last pixel of a line.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (enable) begin
      if (h_cnt_q == HC_W'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        if (v_cnt_q == VC_W'(V_TOTAL - 1)) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Decode of the current count. Range tests use unsigned wrap-around:
  // (a - lo) < len is true exactly for lo <= a < lo+len.
  logic [31:0] h_ext_c, v_ext_c, dx_c, dy_c;
  logic        video_c, draw_c, hs_on_c, vs_on_c;
  vid_out_t    decode_c;

  always_comb begin
    h_ext_c  = 32'(h_cnt_q);
    v_ext_c  = 32'(v_cnt_q);
    dx_c     = h_ext_c - WIN_X0;
    dy_c     = v_ext_c - WIN_Y0;
    video_c  = (h_ext_c < H_ACTIVE) && (v_ext_c < V_ACTIVE);
    draw_c   = video_c && (dx_c < WIN_W) && (dy_c < WIN_H);
    hs_on_c  = (h_ext_c - HS_START) < H_SYNC;
    vs_on_c  = (v_ext_c - VS_START) < V_SYNC;

    decode_c       = RST_OUT;
    decode_c.hs    = hs_on_c ? H_POL : ~H_POL;
    decode_c.vs    = vs_on_c ? V_POL : ~V_POL;
    decode_c.video = video_c;
    decode_c.draw  = draw_c;
    decode_c.x     = draw_c ? X_W'(dx_c >> SCALE_LOG2) : '0;
    decode_c.y     = draw_c ? Y_W'(dy_c >> SCALE_LOG2) : '0;
    decode_c.ls    = (h_cnt_q == '0);
    decode_c.fs    = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Output register plus PIPE delay stages, all frozen together by enable.
  vid_out_t pipe_q [PIPE+1];

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      pipe_q[0] <= RST_OUT;
    end else if (enable) begin
      pipe_q[0] <= decode_c;
    end
  end

  for (genvar g = 1; g <= PIPE; g++) begin : g_pipe
    always_ff @(posedge clk25 or posedge reset) begin
      if (reset) begin
        pipe_q[g] <= RST_OUT;
      end else if (enable) begin
        pipe_q[g] <= pipe_q[g-1];
      end
    end
  end

  assign hSync      = pipe_q[PIPE].hs;
  assign vSync      = pipe_q[PIPE].vs;
  assign video      = pipe_q[PIPE].video;
  assign draw       = pipe_q[PIPE].draw;
  assign xCoord     = pipe_q[PIPE].x;
  assign yCoord     = pipe_q[PIPE].y;
  assign lineStart  = pipe_q[PIPE].ls;
  assign frameStart = pipe_q[PIPE].fs;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync and back porch widths in clocks.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch, sync and back porch widths in lines.
REQ-005 Parameters H_POL / V_POL, default 0 / 0, asserted sync level (0 = active-low).
REQ-006 Parameters WIN_X0 / WIN_Y0, default 0 / 0, draw-window origin in visible pixels and lines.
REQ-007 Parameters WIN_W / WIN_H, default 256 / 320, draw-window size before scaling.
REQ-008 Parameter SCALE_LOG2, default 0, range 0..3, coordinate divide (pixel replication factor 2^SCALE_LOG2).
REQ-009 Parameters X_W / Y_W, default 8 / 9, coordinate output widths.
REQ-010 Parameter PIPE, default 0, range 0..3, extra output delay stages to match downstream memory latency.
REQ-011 clk25  input  1  pixel clock; all state on rising edge.
REQ-012 reset  input  1  asynchronous, active-high reset.
REQ-013 enable  input  1  count advance; when low, counters and outputs hold.
REQ-014 hSync  output  1  horizontal sync, level per H_POL.
REQ-015 vSync  output  1  vertical sync, level per V_POL.
REQ-016 video  output  1  high inside the H_ACTIVE x V_ACTIVE visible area.
REQ-017 draw  output  1  high inside the draw window.
REQ-018 xCoord  output  X_W  scaled window x; 0 when draw low.
REQ-019 yCoord  output  Y_W  scaled window y; 0 when draw low.
REQ-020 lineStart  output  1  one-clock pulse at hCount 0.
REQ-021 frameStart  output  1  one-clock pulse at hCount 0, vCount 0.

Function
REQ-022 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; counter widths = clog2 of totals.
REQ-023 With enable high, hCount increments each clock, wraps H_TOTAL-1 -> 0.
REQ-024 vCount increments only when hCount = H_TOTAL-1; wraps V_TOTAL-1 -> 0 on that same clock.
REQ-025 hSync asserted for hCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], otherwise deasserted.
REQ-026 vSync asserted for vCount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for whole lines (edges aligned to hCount 0).
REQ-027 video = (hCount < H_ACTIVE) & (vCount < V_ACTIVE).
REQ-028 draw = video & hCount in [WIN_X0, WIN_X0+WIN_W-1] & vCount in [WIN_Y0, WIN_Y0+WIN_H-1].
REQ-029 xCoord = (hCount-WIN_X0) >> SCALE_LOG2, truncated to X_W; yCoord likewise with Y_W.
REQ-030 Window clipped to visible area; parts beyond H_ACTIVE/V_ACTIVE never assert draw.
REQ-031 All outputs registered: decode of count state at edge n appears after edge n+1+PIPE.
REQ-032 The PIPE delay stages shift all outputs together; sync/draw/coord alignment preserved.
REQ-033 enable low freezes counters and every pipeline stage; pulses already high stay high until the next enabled edge.

Reset
REQ-034 reset high clears hCount, vCount and all pipeline stages immediately, regardless of clock.
REQ-035 During reset: hSync = ~H_POL, vSync = ~V_POL, video/draw/lineStart/frameStart = 0, coords = 0.
REQ-036 Reset mid-frame abandons the frame; first enabled edge after release decodes count (0,0), so frameStart appears PIPE+1 edges later.

Verification
REQ-037 Defaults, 2 full frames -> 420000 clocks per frame; hSync low exactly 96 clocks starting 656 clocks after each lineStart; vSync low exactly 2 lines.
REQ-038 Defaults -> draw high for hCount 0..255, lines 0..319; xCoord 0..255, yCoord 0..319; coords 0 elsewhere.
REQ-039 WIN_X0=64, WIN_Y0=32, SCALE_LOG2=1 -> first draw at hCount 64 line 32 with xCoord=0; xCoord steps every 2 clocks; yCoord=1 at line 34.
REQ-040 PIPE=2 vs PIPE=0 instances in parallel -> every output identical but delayed exactly 2 clocks.
REQ-041 enable low for 10 clocks at hCount 799, vCount 524 -> outputs hold; on re-enable wrap to (0,0) and frameStart occurs once.
REQ-042 reset asserted asynchronously mid-line (hCount 300, vCount 100), between clock edges -> outputs go to reset values before next edge; after release, frameStart after PIPE+1 enabled edges.
